axis_sha3_block_receiver: RTL and testbench
===========================================

// Module: axis_sha3_block_receiver
// PURPOSE
//  AXI-Stream sink that sits downstream of the 16-bit AXI-Stream transmitter.
//  Packs byte beats little-endian into one SHA3 rate block (default 1088 b = 136 B).
//  Applies SHA3 padding (domain byte 0x06 ... final 0x80) after TLAST.
//  Hands each complete block to the Keccak core over a valid/ready pair.
// PARAMETERS
//  DATA_W     16      TDATA width, bits; must be a multiple of 8
//  RATE_BITS  1088    rate block width, bits; must be a multiple of DATA_W
//  DOMAIN_PAD 8'h06   first pad byte; SHAKE builds use 8'h1F
// PORTS
//  ACLK         in   1           single clock, rising edge
//  ARESETn      in   1           asynchronous, active-low reset
//  TVALID       in   1           upstream beat valid
//  TREADY       out  1           receiver can accept a beat
//  TDATA        in   DATA_W      beat data; TDATA[7:0] is the lower byte address
//  TKEEP        in   DATA_W/8    byte qualifiers; low-aligned contiguous only
//  TLAST        in   1           last beat of the message
//  block_data   out  RATE_BITS   rate block; byte i = block_data[8i+7:8i]
//  block_valid  out  1           block_data is complete and stable
//  block_ready  in   1           Keccak core takes the block
//  block_last   out  1           block carries the padding; message ends here
//  proto_err    out  1           sticky flag for an illegal TKEEP
// BEHAVIOUR
//  Reset (async assert, sync use)
//   - All outputs 0. Buffer 0, byte_cnt 0, pad_pending 0, state FILL.
//   - TREADY rises on the first clock edge after ARESETn deasserts.
//  States
//   - FILL: TREADY=1. A beat is accepted when TVALID&TREADY.
//     - Kept bytes are written at byte_cnt upward; byte_cnt advances by popcount(TKEEP).
//     - Write fills byte RATE_B-1: go HOLD, block_last=0, pad_pending=TLAST.
//     - Else, if TLAST: go PAD.
//   - PAD (1 cycle): TREADY=0.
//     - buf[byte_cnt] ^= DOMAIN_PAD; buf[RATE_B-1] ^= 8'h80.
//     - byte_cnt = RATE_B-1 therefore yields 0x86.
//     - Then go HOLD with block_last=1.
//   - HOLD: TREADY=0, block_valid=1, block_data and block_last held stable.
//     - On block_ready: clear buffer, byte_cnt=0, clear block_valid.
//     - Next state is PAD if pad_pending (clear it), else FILL.
//  Latency
//   - Beat completing a block without pending pad: block_valid at N+1.
//   - TLAST with room left in the block: block_valid at N+2.
//   - TLAST on a full block: a second, pad-only block (06 00..00 80) follows the handshake.
//  TKEEP rules
//   - Accepted values are 2'b11, 2'b01, and 2'b00 only with TLAST (empty message/tail).
//   - 2'b10, or 2'b00 without TLAST: set proto_err, write no bytes, still honour TLAST.
//   - proto_err clears only on reset.
//  Boundary cases
//   - A 2-byte beat never straddles blocks, because RATE_B is even; keep 01 occurs only on TLAST.
//   - block_ready high while block_valid is low is ignored.
//   - Reset mid-block discards the partial block; the next beat lands at byte 0.
// STRUCTURE
//  Package sha3_pkg holds:
//   - RATE_BITS/RATE_B defaults and DOMAIN_PAD constants.
//   - typedef enum {FILL, PAD, HOLD} rx_state_t.
//  Sub-module sha3_byte_writer (combinational): takes buffer, byte_cnt, data, keep, pad_en;
//  returns the next buffer and next byte_cnt. The top level holds the FSM and registers.
// TESTING
//  1 "abc": beats 16'h6261/11, 16'h0063/01+LAST -> bytes 61 62 63 06, 0..., byte135=80;
//    block_last=1; block_valid 2 cycles after last beat.
//  2 Empty message: 1 beat keep 00 + LAST -> byte0=06, byte135=80, rest 0, block_last=1.
//  3 136 B (68 beats, LAST on 68th) -> block A is raw data with last=0;
//    after ready, block B = 06 0..0 80 with last=1.
//  4 135 B (last beat keep 01) -> byte135=8'h86, block_last=1.
//  5 block_ready low 10 cycles in HOLD while TVALID=1 -> TREADY=0, block_data stable, no beat lost.
//  6 ARESETn pulse after 20 beats -> outputs 0 immediately;
//    next "abc" message yields the block of test 1. TKEEP=10 sets proto_err=1.

Source files
------------

// File: rtl/sha3_pkg.sv
// Shared constants, state type and helpers for the AXI-Stream SHA3 rate-block receiver.
package sha3_pkg;

    localparam int         SHA3_RATE_BITS = 1088;
    localparam logic [7:0] PAD_SHA3       = 8'h06;
    localparam logic [7:0] PAD_FINAL      = 8'h80;

    typedef enum logic [1:0] {
        FILL,
        PAD,
        HOLD
    } rx_state_t;

    function automatic int unsigned keep_count(input logic [63:0] keep);
        int unsigned cnt;
        cnt = 0;
        for (int i = 0; i < 64; i++) begin
            cnt += 32'(keep[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/sha3_byte_writer.sv
// Combinational next-buffer logic: drops kept beat bytes at byte_cnt upward and applies
// the SHA3 domain/final pad bytes when pad_en_i is set.
module sha3_byte_writer
    import sha3_pkg::*;
#(
    parameter int         DATA_W     = 16,
    parameter int         RATE_BITS  = SHA3_RATE_BITS,
    parameter logic [7:0] DOMAIN_PAD = PAD_SHA3,
    localparam int        KEEP_W     = DATA_W / 8,
    localparam int        RATE_B     = RATE_BITS / 8,
    localparam int        CNT_W      = $clog2(RATE_B + 1)
) (
    input  logic [RATE_BITS-1:0] buf_i,
    input  logic [CNT_W-1:0]     byte_cnt_i,
    input  logic [DATA_W-1:0]    data_i,
    input  logic [KEEP_W-1:0]    keep_i,
    input  logic                 wr_en_i,
    input  logic                 pad_en_i,
    output logic [RATE_BITS-1:0] buf_o,
    output logic [CNT_W-1:0]     byte_cnt_o
);

    always_comb begin
        // NOTE: every output gets a default first, so no branch can leave one unassigned and infer a latch.
        buf_o      = buf_i;
        byte_cnt_o = byte_cnt_i;

        if (wr_en_i) begin
            // keep_i is low-aligned, so kept byte k lands at byte_cnt + k
            for (int k = 0; k < KEEP_W; k++) begin
                if (keep_i[k] && (int'(byte_cnt_i) + k < RATE_B)) begin
                    buf_o[(int'(byte_cnt_i) + k) * 8 +: 8] = data_i[k * 8 +: 8];
                end
            end
            byte_cnt_o = byte_cnt_i + CNT_W'(keep_count(64'(keep_i)));
        end

        if (pad_en_i) begin
            if (int'(byte_cnt_i) < RATE_B) begin
                buf_o[int'(byte_cnt_i) * 8 +: 8] = buf_o[int'(byte_cnt_i) * 8 +: 8] ^ DOMAIN_PAD;
            end
            buf_o[(RATE_B - 1) * 8 +: 8] = buf_o[(RATE_B - 1) * 8 +: 8] ^ PAD_FINAL;
        end
    end

endmodule

// File: rtl/axis_sha3_block_receiver.sv
// AXI-Stream byte sink that packs beats little-endian into SHA3 rate blocks, pads the
// message tail and hands each block to the Keccak core over a valid/ready pair.
module axis_sha3_block_receiver
    import sha3_pkg::*;
#(
    parameter int         DATA_W     = 16,
    parameter int         RATE_BITS  = SHA3_RATE_BITS,
    parameter logic [7:0] DOMAIN_PAD = PAD_SHA3
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic                  TVALID,
    output logic                  TREADY,
    input  logic [DATA_W-1:0]     TDATA,
    input  logic [DATA_W/8-1:0]   TKEEP,
    input  logic                  TLAST,
    output logic [RATE_BITS-1:0]  block_data,
    output logic                  block_valid,
    input  logic                  block_ready,
    output logic                  block_last,
    output logic                  proto_err
);

    localparam int KEEP_W = DATA_W / 8;
    localparam int RATE_B = RATE_BITS / 8;
    localparam int CNT_W  = $clog2(RATE_B + 1);

    rx_state_t            state_q;
    logic [RATE_BITS-1:0] buf_q, buf_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 pad_pending_q;
    logic                 tready_q;
    logic                 valid_q;
    logic                 last_q;
    logic                 err_q;

    logic                 beat;
    logic                 keep_ok;
    logic [KEEP_W-1:0]    keep_wr;

    assign beat = (state_q == FILL) && TVALID && tready_q;

    // Low-aligned contiguous keep satisfies x & (x+1) == 0; an empty beat is legal only with TLAST
    assign keep_ok = ((TKEEP & (TKEEP + KEEP_W'(1))) == '0) && ((TKEEP != '0) || TLAST);
    assign keep_wr = keep_ok ? TKEEP : '0;

    sha3_byte_writer #(
        .DATA_W     (DATA_W),
        .RATE_BITS  (RATE_BITS),
        .DOMAIN_PAD (DOMAIN_PAD)
    ) u_writer (
        .buf_i      (buf_q),
        .byte_cnt_i (cnt_q),
        .data_i     (TDATA),
        .keep_i     (keep_wr),
        .wr_en_i    (beat),
        .pad_en_i   (state_q == PAD),
        .buf_o      (buf_d),
        .byte_cnt_o (cnt_d)
    );

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q       <= FILL;
            // NOTE: the block buffer is reset, not merely invalidated: padding XORs into it and block_data must read 0.
            buf_q         <= '0;
            cnt_q         <= '0;
            pad_pending_q <= 1'b0;
            tready_q      <= 1'b0;
            valid_q       <= 1'b0;
            last_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            // NOTE: state uses non-blocking assignment so every decision below sees pre-edge values.
            if (beat && !keep_ok) begin
                err_q <= 1'b1;
            end

            unique case (state_q)
                FILL: begin
                    tready_q <= 1'b1;
                    if (beat) begin
                        buf_q <= buf_d;
                        cnt_q <= cnt_d;
                        if (int'(cnt_d) == RATE_B) begin
                            state_q       <= HOLD;
                            tready_q      <= 1'b0;
                            valid_q       <= 1'b1;
                            last_q        <= 1'b0;
                            pad_pending_q <= TLAST;
                        end else if (TLAST) begin
                            state_q  <= PAD;
                            tready_q <= 1'b0;
                        end
                    end
                end
                PAD: begin
                    buf_q   <= buf_d;
                    state_q <= HOLD;
                    valid_q <= 1'b1;
                    last_q  <= 1'b1;
                end
                HOLD: begin
                    if (block_ready) begin
                        buf_q   <= '0;
                        cnt_q   <= '0;
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        if (pad_pending_q) begin
                            // Message ended exactly on a block boundary: emit a pad-only block
                            pad_pending_q <= 1'b0;
                            state_q       <= PAD;
                        end else begin
                            state_q  <= FILL;
                            tready_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end

    assign TREADY      = tready_q;
    assign block_data  = buf_q;
    assign block_valid = valid_q;
    assign block_last  = last_q;
    assign proto_err   = err_q;

endmodule

// File: tb/tb_axis_sha3_block_receiver.sv
// Directed bench for axis_sha3_block_receiver: one task per scenario with hand-built expected blocks.
module tb_axis_sha3_block_receiver;

    localparam int RB = 136;

    logic          ACLK        = 1'b0;
    logic          ARESETn     = 1'b0;
    logic          TVALID      = 1'b0;
    logic [15:0]   TDATA       = '0;
    logic [1:0]    TKEEP       = '0;
    logic          TLAST       = 1'b0;
    logic          block_ready = 1'b0;
    logic          TREADY;
    logic [1087:0] block_data;
    logic          block_valid;
    logic          block_last;
    logic          proto_err;

    int checks = 0;
    int passed = 0;

    always #5 ACLK = ~ACLK;

    axis_sha3_block_receiver dut (
        .ACLK        (ACLK),
        .ARESETn     (ARESETn),
        .TVALID      (TVALID),
        .TREADY      (TREADY),
        .TDATA       (TDATA),
        .TKEEP       (TKEEP),
        .TLAST       (TLAST),
        .block_data  (block_data),
        .block_valid (block_valid),
        .block_ready (block_ready),
        .block_last  (block_last),
        .proto_err   (proto_err)
    );

    function automatic int first_diff(input logic [1087:0] a, input logic [1087:0] b);
        for (int i = 0; i < RB; i++) begin
            if (a[i * 8 +: 8] !== b[i * 8 +: 8]) return i;
        end
        return 0;
    endfunction

    function automatic logic [1087:0] pad_only_block();
        logic [1087:0] e;
        e = '0;
        e[7:0] = 8'h06;
        e[(RB - 1) * 8 +: 8] = 8'h80;
        return e;
    endfunction

    function automatic logic [1087:0] abc_block();
        logic [1087:0] e;
        e = '0;
        e[7:0]   = 8'h61;
        e[15:8]  = 8'h62;
        e[23:16] = 8'h63;
        e[31:24] = 8'h06;
        e[(RB - 1) * 8 +: 8] = 8'h80;
        return e;
    endfunction

    // Presents one beat starting at a falling edge; returns at the falling edge after its acceptance.
    task automatic send_beat(input logic [15:0] d, input logic [1:0] k, input logic l);
        int n;
        TVALID = 1'b1;
        TDATA  = d;
        TKEEP  = k;
        TLAST  = l;
        n = 0;
        while (TREADY !== 1'b1 && n < 200) begin
            @(negedge ACLK);
            n++;
        end
        if (TREADY !== 1'b1) begin
            checks++;
            $display("FAIL beat_timeout: TREADY=%b after %0d cycles, required 1", TREADY, n);
        end
        @(negedge ACLK);
        TVALID = 1'b0;
        TDATA  = '0;
        TKEEP  = '0;
        TLAST  = 1'b0;
    endtask

    task automatic take_block();
        block_ready = 1'b1;
        @(negedge ACLK);
        block_ready = 1'b0;
    endtask

    task automatic test_reset();
        ARESETn = 1'b0;
        #2;
        checks++;
        if ({TREADY, block_valid, block_last, proto_err} !== 4'b0000)
            $display("FAIL reset_flags: ready/valid/last/err=%b required 0000",
                     {TREADY, block_valid, block_last, proto_err});
        else passed++;
        checks++;
        if (block_data !== '0)
            $display("FAIL reset_data: byte %0d = %h required 00", first_diff(block_data, '0),
                     block_data[first_diff(block_data, '0) * 8 +: 8]);
        else passed++;
        @(negedge ACLK);
        @(negedge ACLK);
        ARESETn = 1'b1;
        #1;
        checks++;
        if (TREADY !== 1'b0) $display("FAIL reset_tready_release: TREADY=%b required 0", TREADY);
        else passed++;
        @(negedge ACLK);
        checks++;
        if (TREADY !== 1'b1) $display("FAIL reset_tready_rise: TREADY=%b required 1", TREADY);
        else passed++;
    endtask

    task automatic test_abc();
        logic [1087:0] e;
        int d;
        e = abc_block();
        send_beat(16'h6261, 2'b11, 1'b0);
        send_beat(16'h0063, 2'b01, 1'b1);
        checks++;
        if (block_valid !== 1'b0) $display("FAIL abc_pad_cycle: valid=%b required 0", block_valid);
        else passed++;
        @(negedge ACLK);
        checks++;
        if (block_valid !== 1'b1 || block_last !== 1'b1 || TREADY !== 1'b0)
            $display("FAIL abc_hold: valid/last/ready=%b%b%b required 110", block_valid, block_last, TREADY);
        else passed++;
        checks++;
        if (block_data !== e) begin
            d = first_diff(block_data, e);
            $display("FAIL abc_data: byte %0d = %h required %h", d, block_data[d * 8 +: 8], e[d * 8 +: 8]);
        end else passed++;
        take_block();
        checks++;
        if (block_valid !== 1'b0) $display("FAIL abc_release: valid=%b required 0", block_valid);
        else passed++;
    endtask

    task automatic test_empty();
        logic [1087:0] e;
        int d;
        e = pad_only_block();
        send_beat(16'h0000, 2'b00, 1'b1);
        @(negedge ACLK);
        checks++;
        if (block_valid !== 1'b1 || block_last !== 1'b1 || proto_err !== 1'b0)
            $display("FAIL empty_flags: valid/last/err=%b%b%b required 110", block_valid, block_last, proto_err);
        else passed++;
        checks++;
        if (block_data !== e) begin
            d = first_diff(block_data, e);
            $display("FAIL empty_data: byte %0d = %h required %h", d, block_data[d * 8 +: 8], e[d * 8 +: 8]);
        end else passed++;
        take_block();
    endtask

    task automatic test_back_to_back();
        logic [1087:0] e;
        int d;
        e = '0;
        for (int i = 0; i < RB; i++) e[i * 8 +: 8] = 8'(i);
        for (int j = 0; j < 68; j++) send_beat({8'(2 * j + 1), 8'(2 * j)}, 2'b11, j == 67);
        checks++;
        if (block_valid !== 1'b1 || block_last !== 1'b0 || TREADY !== 1'b0)
            $display("FAIL full_a_flags: valid/last/ready=%b%b%b required 100", block_valid, block_last, TREADY);
        else passed++;
        checks++;
        if (block_data !== e) begin
            d = first_diff(block_data, e);
            $display("FAIL full_a_data: byte %0d = %h required %h", d, block_data[d * 8 +: 8], e[d * 8 +: 8]);
        end else passed++;
        take_block();
        checks++;
        if (block_valid !== 1'b0 || TREADY !== 1'b0)
            $display("FAIL full_pad_cycle: valid/ready=%b%b required 00", block_valid, TREADY);
        else passed++;
        @(negedge ACLK);
        e = pad_only_block();
        checks++;
        if (block_valid !== 1'b1 || block_last !== 1'b1)
            $display("FAIL full_b_flags: valid/last=%b%b required 11", block_valid, block_last);
        else passed++;
        checks++;
        if (block_data !== e) begin
            d = first_diff(block_data, e);
            $display("FAIL full_b_data: byte %0d = %h required %h", d, block_data[d * 8 +: 8], e[d * 8 +: 8]);
        end else passed++;
        take_block();
    endtask

    task automatic test_135_bytes();
        logic [1087:0] e;
        int d;
        e = '0;
        for (int i = 0; i < RB - 1; i++) e[i * 8 +: 8] = 8'(i + 1);
        e[(RB - 1) * 8 +: 8] = 8'h86;
        for (int j = 0; j < 67; j++) send_beat({8'(2 * j + 2), 8'(2 * j + 1)}, 2'b11, 1'b0);
        send_beat({8'h00, 8'(135)}, 2'b01, 1'b1);
        @(negedge ACLK);
        checks++;
        if (block_valid !== 1'b1 || block_last !== 1'b1)
            $display("FAIL b135_flags: valid/last=%b%b required 11", block_valid, block_last);
        else passed++;
        checks++;
        if (block_data[(RB - 1) * 8 +: 8] !== 8'h86)
            $display("FAIL b135_last_byte: byte135 = %h required 86", block_data[(RB - 1) * 8 +: 8]);
        else passed++;
        checks++;
        if (block_data !== e) begin
            d = first_diff(block_data, e);
            $display("FAIL b135_data: byte %0d = %h required %h", d, block_data[d * 8 +: 8], e[d * 8 +: 8]);
        end else passed++;
        take_block();
    endtask

    task automatic test_hold_stall();
        logic [1087:0] e;
        int d;
        e = '0;
        for (int i = 0; i < RB; i++) e[i * 8 +: 8] = 8'(i) ^ 8'h5A;
        for (int j = 0; j < 68; j++) send_beat({8'(2 * j + 1) ^ 8'h5A, 8'(2 * j) ^ 8'h5A}, 2'b11, 1'b0);
        TVALID = 1'b1;
        TDATA  = 16'hBEEF;
        TKEEP  = 2'b11;
        TLAST  = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge ACLK);
            checks++;
            if (TREADY !== 1'b0 || block_valid !== 1'b1 || block_last !== 1'b0 || block_data !== e) begin
                d = first_diff(block_data, e);
                $display("FAIL stall_cycle%0d: ready/valid/last=%b%b%b byte %0d = %h required 010 and %h",
                         c, TREADY, block_valid, block_last, d, block_data[d * 8 +: 8], e[d * 8 +: 8]);
            end else passed++;
        end
        take_block();
        send_beat(16'hBEEF, 2'b11, 1'b1);
        @(negedge ACLK);
        e = '0;
        e[7:0]   = 8'hEF;
        e[15:8]  = 8'hBE;
        e[23:16] = 8'h06;
        e[(RB - 1) * 8 +: 8] = 8'h80;
        checks++;
        if (block_valid !== 1'b1 || block_last !== 1'b1 || block_data !== e) begin
            d = first_diff(block_data, e);
            $display("FAIL stall_held_beat: valid/last=%b%b byte %0d = %h required 11 and %h",
                     block_valid, block_last, d, block_data[d * 8 +: 8], e[d * 8 +: 8]);
        end else passed++;
        take_block();
    endtask

    task automatic test_reset_mid_block();
        logic [1087:0] e;
        int d;
        for (int j = 0; j < 20; j++) send_beat(16'hFFFF, 2'b11, 1'b0);
        ARESETn = 1'b0;
        #1;
        checks++;
        if ({TREADY, block_valid, block_last, proto_err} !== 4'b0000 || block_data !== '0)
            $display("FAIL midreset_outputs: ready/valid/last/err=%b byte %0d = %h required 0000 and 00",
                     {TREADY, block_valid, block_last, proto_err}, first_diff(block_data, '0),
                     block_data[first_diff(block_data, '0) * 8 +: 8]);
        else passed++;
        @(negedge ACLK);
        ARESETn = 1'b1;
        @(negedge ACLK);
        // Stray block_ready while no block is valid must be ignored
        block_ready = 1'b1;
        send_beat(16'h6261, 2'b11, 1'b0);
        send_beat(16'h0063, 2'b01, 1'b1);
        block_ready = 1'b0;
        @(negedge ACLK);
        e = abc_block();
        checks++;
        if (block_valid !== 1'b1 || block_last !== 1'b1 || block_data !== e) begin
            d = first_diff(block_data, e);
            $display("FAIL midreset_abc: valid/last=%b%b byte %0d = %h required 11 and %h",
                     block_valid, block_last, d, block_data[d * 8 +: 8], e[d * 8 +: 8]);
        end else passed++;
        take_block();
    endtask

    task automatic test_proto_err();
        logic [1087:0] e;
        int d;
        send_beat(16'h1234, 2'b10, 1'b1);
        checks++;
        if (proto_err !== 1'b1) $display("FAIL perr_set: proto_err=%b required 1", proto_err);
        else passed++;
        @(negedge ACLK);
        e = pad_only_block();
        checks++;
        if (block_valid !== 1'b1 || block_last !== 1'b1 || block_data !== e) begin
            d = first_diff(block_data, e);
            $display("FAIL perr_block: valid/last=%b%b byte %0d = %h required 11 and %h",
                     block_valid, block_last, d, block_data[d * 8 +: 8], e[d * 8 +: 8]);
        end else passed++;
        take_block();
        repeat (3) @(negedge ACLK);
        checks++;
        if (proto_err !== 1'b1) $display("FAIL perr_sticky: proto_err=%b required 1", proto_err);
        else passed++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_abc();
        test_empty();
        test_back_to_back();
        test_135_bytes();
        test_hold_stall();
        test_reset_mid_block();
        test_proto_err();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
